// File: rtl/bp_stream_nbf_responder.sv
// bp_stream_nbf_responder: packs uncached BedRock forward commands into NBF records, streams them to the host and returns reverse responses
// Header layout (LSB first): msg_type[3:0], subop[7:4], addr[paddr], size[3], payload.
module bp_stream_nbf_responder
  #(parameter int paddr_width_p = 40
   ,parameter int io_data_width_p = 64
   ,parameter int payload_width_p = 16
   ,parameter int stream_data_width_p = 32
   ,parameter int nbf_opcode_width_p = 8
   ,parameter int nbf_addr_width_p = paddr_width_p
   ,parameter int nbf_data_width_p = 64
   ,localparam int mem_header_width_lp = payload_width_p + 3 + paddr_width_p + 8
   )
  (input  logic                            clk_i
  ,input  logic                            reset_i
  ,input  logic [mem_header_width_lp-1:0]  mem_fwd_header_i
  ,input  logic                            mem_fwd_header_v_i
  ,output logic                            mem_fwd_header_ready_and_o
  ,input  logic                            mem_fwd_has_data_i
  ,input  logic [io_data_width_p-1:0]      mem_fwd_data_i
  ,input  logic                            mem_fwd_data_v_i
  ,output logic                            mem_fwd_data_ready_and_o
  ,input  logic                            mem_fwd_last_i
  ,output logic [mem_header_width_lp-1:0]  mem_rev_header_o
  ,output logic                            mem_rev_header_v_o
  ,input  logic                            mem_rev_header_ready_and_i
  ,output logic                            mem_rev_has_data_o
  ,output logic [io_data_width_p-1:0]      mem_rev_data_o
  ,output logic                            mem_rev_data_v_o
  ,input  logic                            mem_rev_data_ready_and_i
  ,output logic                            mem_rev_last_o
  ,output logic                            stream_v_o
  ,input  logic                            stream_ready_and_i
  ,output logic [stream_data_width_p-1:0]  stream_data_o
  ,input  logic                            stream_v_i
  ,output logic                            stream_ready_o
  ,input  logic [stream_data_width_p-1:0]  stream_data_i
  );

   localparam int rec_w = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
   localparam int nbf_num_flits_lp = (rec_w + stream_data_width_p - 1) / stream_data_width_p;
   localparam int rd_num_flits_lp = (nbf_data_width_p + stream_data_width_p - 1) / stream_data_width_p;
   localparam int pad_w = nbf_num_flits_lp * stream_data_width_p;
   localparam int rd_w = rd_num_flits_lp * stream_data_width_p;
   localparam int cw = nbf_num_flits_lp > 1 ? $clog2(nbf_num_flits_lp) : 1;
   localparam int rcw = rd_num_flits_lp > 1 ? $clog2(rd_num_flits_lp) : 1;
   localparam logic [cw-1:0] flit_last = cw'(nbf_num_flits_lp - 1);
   localparam logic [rcw-1:0] rd_last = rcw'(rd_num_flits_lp - 1);

   typedef enum logic [1:0] {READY, SEND, RD_WAIT, RESP} state_e;

   state_e state, state_n;
   logic [cw-1:0] cnt;
   logic [rcw-1:0] rcnt;
   logic h_done, d_done, rd_r, accept, rd_n, wr_n, unused;
   logic [1:0] s_r, s_n;
   logic [2:0] size;
   logic [nbf_opcode_width_p-1:0] op_n;
   logic [nbf_data_width_p-1:0] d_in, wdata;
   logic [mem_header_width_lp-1:0] hdr_r;
   logic [rec_w-1:0] rec_r, rec_n;
   logic [nbf_num_flits_lp-1:0][stream_data_width_p-1:0] flits;
   logic [rd_num_flits_lp-1:0][stream_data_width_p-1:0] rdata;
   logic [rd_w-1:0] rd_flat;
   logic [io_data_width_p-1:0] rep;

   assign unused = mem_fwd_last_i;

   // Build the NBF record from the command currently offered on the forward port
   always_comb begin
      size  = mem_fwd_header_i[8+paddr_width_p +: 3];
      s_n   = size > 3'd3 ? 2'd3 : size[1:0];
      rd_n  = mem_fwd_header_i[3:0] == 4'd2;
      wr_n  = mem_fwd_header_i[3:0] == 4'd3;
      op_n  = rd_n ? nbf_opcode_width_p'({3'b100, s_n})
            : wr_n ? nbf_opcode_width_p'(s_n)
            : nbf_opcode_width_p'(8'hFE);
      d_in  = (mem_fwd_has_data_i & ~rd_n) ? mem_fwd_data_i[nbf_data_width_p-1:0] : '0;
      wdata = s_n == 2'd0 ? nbf_data_width_p'(d_in[7:0])
            : s_n == 2'd1 ? nbf_data_width_p'(d_in[15:0])
            : s_n == 2'd2 ? nbf_data_width_p'(d_in[31:0])
            : d_in;
      rec_n = {op_n, nbf_addr_width_p'(mem_fwd_header_i[8 +: paddr_width_p]), wdata};
   end

   // Next state and handshake outputs; every output defaults low
   always_comb begin
      state_n            = state;
      accept             = 1'b0;
      stream_v_o         = 1'b0;
      stream_ready_o     = 1'b0;
      mem_rev_header_v_o = 1'b0;
      mem_rev_data_v_o   = 1'b0;
      case (state)
         READY: begin
            accept  = mem_fwd_header_v_i & (~mem_fwd_has_data_i | mem_fwd_data_v_i);
            state_n = accept ? SEND : READY;
         end
         SEND: begin
            stream_v_o = 1'b1;
            state_n    = (stream_ready_and_i && cnt == flit_last) ? (rd_r ? RD_WAIT : RESP) : SEND;
         end
         RD_WAIT: begin
            stream_ready_o = 1'b1;
            state_n        = (stream_v_i && rcnt == rd_last) ? RESP : RD_WAIT;
         end
         default: begin
            mem_rev_header_v_o = ~h_done;
            mem_rev_data_v_o   = rd_r & ~d_done;
            state_n = ((h_done | mem_rev_header_ready_and_i)
                       & (~rd_r | d_done | mem_rev_data_ready_and_i)) ? READY : RESP;
         end
      endcase
   end

   assign mem_fwd_header_ready_and_o = accept;
   assign mem_fwd_data_ready_and_o   = accept;

   assign flits   = pad_w'(rec_r);
   assign rd_flat = rdata;
   assign rep = s_r == 2'd0 ? {(io_data_width_p/8){rd_flat[7:0]}}
              : s_r == 2'd1 ? {(io_data_width_p/16){rd_flat[15:0]}}
              : s_r == 2'd2 ? {(io_data_width_p/32){rd_flat[31:0]}}
              : {(io_data_width_p/64){rd_flat[63:0]}};

   assign stream_data_o      = state == SEND ? flits[cnt] : '0;
   assign mem_rev_header_o   = state == RESP ? hdr_r : '0;
   assign mem_rev_has_data_o = state == RESP & rd_r;
   assign mem_rev_data_o     = (state == RESP & rd_r) ? rep : '0;
   assign mem_rev_last_o     = mem_rev_data_v_o;

   // State, flit counters and response completion flags
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state  <= READY;
         cnt    <= '0;
         rcnt   <= '0;
         h_done <= 1'b0;
         d_done <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= accept ? '0 : cnt + cw'(stream_v_o & stream_ready_and_i);
         rcnt   <= accept ? '0 : rcnt + rcw'(stream_ready_o & stream_v_i);
         h_done <= ~accept & (h_done | (mem_rev_header_v_o & mem_rev_header_ready_and_i));
         d_done <= ~accept & (d_done | (mem_rev_data_v_o & mem_rev_data_ready_and_i));
      end
   end

   // Command capture and inbound read-data capture
   always_ff @(posedge clk_i) begin
      if (accept) begin
         hdr_r <= mem_fwd_header_i;
         rec_r <= rec_n;
         rd_r  <= rd_n;
         s_r   <= s_n;
      end
      if (stream_ready_o & stream_v_i)
         rdata[rcnt] <= stream_data_i;
   end

endmodule
